// File: rtl/fetch_unit.sv
// fetch_unit: program-counter and instruction-fetch sequencer for the RV32I core.
//
// This block owns the PC. It fetches one word from instruction memory over a
// req/ack handshake and holds that word for decode and execute. It then picks
// the next PC from either the sequential path or the branch target. A
// control-flow target that is not word aligned locks the unit in a sticky
// fault state.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   NextPCSrc       1 = take target, 0 = pc + 4 (sampled in EXEC when not stalled)
//   target          branch/jump target from the ALU
//   stall           freezes the held instruction while in EXEC
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address (always equals pc)
//   imem_ack        imem_rdata is valid this cycle
//   imem_rdata      instruction word from memory
//   instr           held instruction (NOP_INSTR when nothing valid is held)
//   instr_valid     instr is valid for decode
//   pc, pc_plus4    current PC and its sequential successor (link value)
//   misalign_fault  sticky misaligned-target flag
//   instret         retired-instruction counter
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one cycle after reset, no request outstanding
// S_FETCH | request outstanding at pc, waiting for imem_ack
// S_EXEC  | instruction held for decode/execute, next PC chosen here
// S_FAULT | misaligned target seen; frozen until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_fault,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic        fault_q;
  logic [31:0] instret_q;
  logic [31:0] npc_d;

  // The sequential path wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Bit 0 of a jump target is always dropped (JALR semantics). Bit 1 is left
  // in place so that the EXEC state can detect a misaligned target.
  assign npc_d = NextPCSrc ? (target & ~32'h0000_0001) : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            // The offending instruction does not retire. The PC is kept so
            // that it still points at the instruction that faulted.
            if (npc_d[1]) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
              valid_q <= 1'b0;
              instr_q <= NOP_INSTR;
            end else begin
              pc_q      <= npc_d;
              instret_q <= instret_q + 32'd1;
              instr_q   <= NOP_INSTR;
              valid_q   <= 1'b0;
              req_q     <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign misalign_fault = fault_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        NextPCSrc = 1'b0;
  logic [31:0] target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_fault;
  logic [31:0] instret;

  // Second instance with a reset PC at the top of the address space.
  logic        rst_w = 1'b1;
  logic        ack_w = 1'b1;
  logic        src_w = 1'b0;
  logic        stall_w = 1'b0;
  logic [31:0] target_w = 32'd0;
  logic        req_w;
  logic [31:0] addr_w;
  logic [31:0] rdata_w;
  logic [31:0] instr_w;
  logic        valid_w;
  logic [31:0] pc_w;
  logic [31:0] pc_plus4_w;
  logic        fault_w;
  logic [31:0] instret_w;

  logic [31:0] exp_addr_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mkword(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Memory model: a valid word only in the ack cycle, garbage otherwise.
  assign imem_rdata = imem_ack ? mkword(imem_addr) : 32'hDEAD_BEEF;
  assign rdata_w    = mkword(addr_w);

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .target(target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misalign_fault(misalign_fault), .instret(instret)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w), .NextPCSrc(src_w), .target(target_w), .stall(stall_w),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w),
    .imem_rdata(rdata_w), .instr(instr_w), .instr_valid(valid_w),
    .pc(pc_w), .pc_plus4(pc_plus4_w), .misalign_fault(fault_w), .instret(instret_w)
  );

  // Scoreboard: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ack) begin
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++;
        $display("FAIL sb_fetch: unexpected fetch at addr=%h, none expected", imem_addr);
      end else begin
        logic [31:0] e;
        e = exp_addr_q.pop_front();
        if (imem_addr !== e) begin
          bad++;
          $display("FAIL sb_fetch: addr=%h expected=%h", imem_addr, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; NextPCSrc = 1'b0; stall = 1'b0;
    tick(); tick();
    total++;
    if (pc !== 32'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: pc=%h req=%b valid=%b expected 0/0/0", pc, imem_req, instr_valid);
    end
    total++;
    if (instr !== NOP || misalign_fault !== 1'b0 || instret !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs: instr=%h fault=%b instret=%0d expected %h/0/0", instr, misalign_fault, instret, NOP);
    end
  endtask

  task automatic test_sequential();
    exp_addr_q.push_back(32'd0);
    exp_addr_q.push_back(32'd4);
    exp_addr_q.push_back(32'd8);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(4 * i)) begin
        bad++;
        $display("FAIL seq_fetch%0d: req=%b valid=%b addr=%h expected 1/0/%h", i, imem_req, instr_valid, imem_addr, 32'(4 * i));
      end
      tick();
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mkword(32'(4 * i))) begin
        bad++;
        $display("FAIL seq_exec%0d: valid=%b req=%b instr=%h expected 1/0/%h", i, instr_valid, imem_req, instr, mkword(32'(4 * i)));
      end
      tick();
    end
    imem_ack = 1'b0;
    total++;
    if (instret !== 32'd3 || pc !== 32'd12) begin
      bad++;
      $display("FAIL seq_instret: instret=%0d pc=%h expected 3/0000000c", instret, pc);
    end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1;
    exp_addr_q.push_back(32'd12);
    tick();
    exp_addr_q.push_back(32'h10);
    tick();
    total++;
    if (pc !== 32'h10 || pc_plus4 !== 32'h14) begin
      bad++;
      $display("FAIL br_pc10: pc=%h pc_plus4=%h expected 00000010/00000014", pc, pc_plus4);
    end
    tick();
    NextPCSrc = 1'b1; target = 32'h41;
    exp_addr_q.push_back(32'h40);
    tick();
    total++;
    if (imem_addr !== 32'h40 || imem_req !== 1'b1 || instret !== 32'd5) begin
      bad++;
      $display("FAIL br_jalr_clear: addr=%h req=%b instret=%0d expected 00000040/1/5", imem_addr, imem_req, instret);
    end
    target = 32'h20;
    tick();
    exp_addr_q.push_back(32'h20);
    tick();
    total++;
    if (pc !== 32'h20 || instret !== 32'd6) begin
      bad++;
      $display("FAIL br_target20: pc=%h instret=%0d expected 00000020/6", pc, instret);
    end
    NextPCSrc = 1'b0;
    tick();
  endtask

  task automatic test_misalign();
    int req_seen;
    NextPCSrc = 1'b1; target = 32'h42;
    tick();
    NextPCSrc = 1'b0;
    total++;
    if (misalign_fault !== 1'b1 || pc !== 32'h20 || instret !== 32'd6) begin
      bad++;
      $display("FAIL mis_fault: fault=%b pc=%h instret=%0d expected 1/00000020/6", misalign_fault, pc, instret);
    end
    total++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      bad++;
      $display("FAIL mis_outputs: valid=%b instr=%h expected 0/%h", instr_valid, instr, NOP);
    end
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req !== 1'b0 || misalign_fault !== 1'b1) req_seen++;
    end
    total++;
    if (req_seen != 0 || pc !== 32'h20 || instret !== 32'd6) begin
      bad++;
      $display("FAIL mis_hold: bad_cycles=%0d pc=%h instret=%0d expected 0/00000020/6", req_seen, pc, instret);
    end
    rst = 1'b1;
    tick();
    total++;
    if (misalign_fault !== 1'b0 || pc !== 32'd0 || instret !== 32'd0) begin
      bad++;
      $display("FAIL mis_clear: fault=%b pc=%h instret=%0d expected 0/0/0", misalign_fault, pc, instret);
    end
    rst = 1'b0;
  endtask

  task automatic test_stall_slow_mem();
    int bad_cycles;
    imem_ack = 1'b0;
    tick();
    exp_addr_q.push_back(32'd0);
    bad_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) bad_cycles++;
      tick();
    end
    total++;
    if (bad_cycles != 0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL slow_hold: bad_cycles=%0d req=%b addr=%h expected 0/1/0", bad_cycles, imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    total++;
    if (instr !== mkword(32'd0) || instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL slow_data: instr=%h valid=%b expected %h/1", instr, instr_valid, mkword(32'd0));
    end
    stall = 1'b1; NextPCSrc = 1'b1; target = 32'h100;
    bad_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc !== 32'd0 || instr !== mkword(32'd0) || instret !== 32'd0 ||
          instr_valid !== 1'b1 || imem_req !== 1'b0) bad_cycles++;
    end
    total++;
    if (bad_cycles != 0) begin
      bad++;
      $display("FAIL stall_freeze: bad_cycles=%0d expected 0 (pc=%h instret=%0d)", bad_cycles, pc, instret);
    end
    stall = 1'b0; NextPCSrc = 1'b0;
    exp_addr_q.push_back(32'd4);
    tick();
    total++;
    if (pc !== 32'd4 || instret !== 32'd1 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: pc=%h instret=%0d req=%b expected 00000004/1/1", pc, instret, imem_req);
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    // Now in FETCH at pc=8 with ack high: reset in the same cycle.
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
      bad++;
      $display("FAIL rmf_setup: req=%b addr=%h expected 1/00000008", imem_req, imem_addr);
    end
    rst = 1'b1;
    tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== NOP || pc !== 32'd0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rmf_abort: valid=%b instr=%h pc=%h req=%b expected 0/%h/0/0", instr_valid, instr, pc, imem_req, NOP);
    end
    rst = 1'b0;
    exp_addr_q.push_back(32'd0);
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rmf_idle: req=%b expected 0", imem_req);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL rmf_restart: req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    rst_w = 1'b1;
    tick(); tick();
    total++;
    if (pc_w !== 32'hFFFF_FFFC || pc_plus4_w !== 32'd0 || instr_w !== NOP) begin
      bad++;
      $display("FAIL wrap_reset: pc=%h pc_plus4=%h instr=%h expected fffffffc/0/%h", pc_w, pc_plus4_w, instr_w, NOP);
    end
    rst_w = 1'b0;
    tick();
    total++;
    if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_first: req=%b addr=%h expected 1/fffffffc", req_w, addr_w);
    end
    tick(); tick();
    total++;
    if (req_w !== 1'b1 || addr_w !== 32'd0 || fault_w !== 1'b0 || instret_w !== 32'd1 || valid_w !== 1'b0) begin
      bad++;
      $display("FAIL wrap_second: req=%b addr=%h fault=%b instret=%0d valid=%b expected 1/0/0/1/0",
               req_w, addr_w, fault_w, instret_w, valid_w);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misalign();
    test_stall_slow_mem();
    test_reset_mid_fetch();
    test_wrap();
    total++;
    if (exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending=%0d expected 0", exp_addr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
